dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DMEM) between the CPU MEM stage and a debug/loader port (testbench or debug module preload/inspect).
- Sits between the CPU core and DMEM inside the top level. Sequences each access as issue → wait → respond and produces the CPU stall.
- CPU has fixed priority. A bounded-wait counter guarantees the debug port progress.

Parameters:
- ADDR_W, 8, DMEM word-address width (256 words).
- DATA_W, 32, data width.
- RD_LAT, 1, DMEM read latency in cycles after the mem_en cycle; must be ≥1.
- MAX_WAIT, 4, number of consecutive lost arbitrations after which debug wins the next arbitration.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  byte enables, writes only
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid with cpu_ready
- cpu_stall  out  1  cpu_req & ~cpu_ready (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb, dbg_ready, dbg_rdata  same as cpu_*
- mem_en  out  1  DMEM access strobe
- mem_we  out  1  DMEM write enable
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- mem_wstrb  out  DATA_W/8
- mem_rdata  in  DATA_W  valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE, owner = CPU, wait_cnt = 0.
  - All ready, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, mem_wstrb, cpu_rdata and dbg_rdata = 0.
- Reset mid-operation: any in-flight access is abandoned and no ready is issued. Requesters must reissue.
- Requester protocol:
  - Assert req with command stable until the ready pulse.
  - req may stay high after ready; it is then treated as a new request, arbitrated in the next IDLE.
  - If req drops early, the latched access still completes and ready still pulses.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any req is high, latch the winner's command and owner, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_en = 1 and mem_* = latched command. Writes go to RESP; reads go to WAIT with rd_cnt = RD_LAT.
  - WAIT: decrement rd_cnt. When rd_cnt reaches 1, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP (1 cycle): owner's ready = 1, then go to IDLE.
- Latency, counting the cycle in which IDLE samples req as cycle 0:
  - Write: mem_en in cycle 1, ready in cycle 2.
  - Read: ready in cycle 2+RD_LAT (cycle 3 at the default).
  - Throughput: one access per 3 cycles for writes, 3+RD_LAT for reads.
- Arbitration, evaluated in IDLE only:
  - Only cpu_req: CPU wins. Only dbg_req: debug wins.
  - Both requesting: CPU wins unless wait_cnt == MAX_WAIT, in which case debug wins.
  - wait_cnt increments (saturating at MAX_WAIT) each time debug loses while requesting.
  - wait_cnt clears when debug is granted, or when IDLE samples dbg_req low.
- Non-owner outputs:
  - The non-owner's ready stays 0 throughout.
  - Its rdata holds its last captured value (unchanged by the other port's reads).
- Write data: mem_wstrb is forced to 0 on reads. Data and strobes pass through unmodified on writes.
- mem_* outputs are registered and driven only in ISSUE; mem_en and mem_we = 0 in all other states. Address bits pass through unmodified, with no range check.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, two output ports are added:
  - perf_conflict_cnt (32): counts IDLE cycles where cpu_req and dbg_req are both high.
  - perf_cpu_stall_cnt (32): counts cycles with cpu_stall = 1.
- Both counters reset to 0, wrap modulo 2^32 and do not affect arbitration.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - the owner encoding: OWN_CPU=1'b0, OWN_DBG=1'b1;
  - default parameter constants.
- Sub-module dmem_arb_prio holds the combinational winner select plus the wait_cnt register and saturation. The top block holds the FSM, latches and read capture.

Test Plan:
- CPU write then read, RD_LAT=1:
  - Write addr 8'h10 data 32'hDEADBEEF strb 4'hF → mem_en in cycle 1, cpu_ready in cycle 2.
  - Read addr 8'h10 → cpu_rdata = DEADBEEF with cpu_ready in cycle 3.
  - cpu_stall is high on every cycle before ready.
- Contention, MAX_WAIT=4:
  - cpu_req and dbg_req held high continuously → CPU granted 4 times, then debug on the 5th, then CPU again.
  - dbg_ready pulses exactly once per 5 grants.
- Byte strobe: debug write addr 8'h03 data 32'h000000AA strb 4'b0001 → mem_wstrb = 1 for one cycle. Strobe is 0 on a subsequent read.
- RD_LAT=3:
  - Read request → ready exactly in cycle 5.
  - mem_rdata value presented in cycle 4 is the value returned.
- Reset mid-read: assert reset in the WAIT state → next cycle state is IDLE, no ready pulses, mem_en = 0. A reissued request completes normally.
- With DMEM_ARB_PERF_EN: 6 IDLE cycles with both requests high → perf_conflict_cnt = 6. Reset → both counters 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default constants for the DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed CPU priority with a bounded-wait counter that lets debug win after
// MAX_WAIT consecutive lost arbitrations.
module dmem_arb_prio import dmem_arb_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   dbg_req,
  output owner_e winner,
  output logic   grant_valid
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              wait_full;

  assign wait_full = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    if (dbg_req && (!cpu_req || wait_full)) begin
      winner = OWN_DBG;
    end else begin
      winner = OWN_CPU;
    end
    // The counter only moves on IDLE sampling cycles.
    if (!arb_en) begin
      wait_cnt_d = wait_cnt_q;
    end else if (!dbg_req || winner == OWN_DBG) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if (!wait_full) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= {WAIT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter for the single-port DMEM: issue -> wait -> respond.
// Optional performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wstrb,
  output logic                dbg_ready,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_cpu_stall_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(RD_LAT + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d, winner;
  logic              grant_valid, rd_done, resp_next;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              cpu_ready_q, cpu_ready_d, dbg_ready_q, dbg_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;

  dmem_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk         (clk),
    .reset       (reset),
    .arb_en      (state_q == IDLE),
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .winner      (winner),
    .grant_valid (grant_valid)
  );

  assign rd_done = (state_q == WAIT) && (rd_cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (mem_we_q) state_d = RESP; else state_d = WAIT;
      WAIT:    if (rd_done) state_d = RESP; else state_d = WAIT;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so that every port leaves a flop.
  always_comb begin
    owner_d     = owner_q;
    rd_cnt_d    = rd_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    resp_next   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d  = winner;
          mem_en_d = 1'b1;
          if (winner == OWN_DBG) begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            mem_wstrb_d = dbg_we ? dbg_wstrb : {STRB_W{1'b0}};
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_wstrb_d = cpu_we ? cpu_wstrb : {STRB_W{1'b0}};
          end
        end else begin
          owner_d = owner_q;
        end
      end
      ISSUE: begin
        if (mem_we_q) resp_next = 1'b1; else rd_cnt_d = CNT_W'(RD_LAT);
      end
      WAIT: begin
        if (rd_done) begin
          resp_next = 1'b1;
          if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata; else cpu_rdata_d = mem_rdata;
        end else begin
          rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
      end
      RESP:    rd_cnt_d = {CNT_W{1'b0}};
      default: rd_cnt_d = {CNT_W{1'b0}};
    endcase
    cpu_ready_d = resp_next && (owner_q == OWN_CPU);
    dbg_ready_d = resp_next && (owner_q == OWN_DBG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      rd_cnt_q    <= {CNT_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_wstrb_q <= {STRB_W{1'b0}};
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
      dbg_rdata_q <= {DATA_W{1'b0}};
    end else begin
      owner_q     <= owner_d;
      rd_cnt_q    <= rd_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q + ((state_q == IDLE && cpu_req && dbg_req) ? 32'd1 : 32'd0);
    perf_stall_d    = perf_stall_q + (cpu_stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_q <= 32'd0;
      perf_stall_q    <= 32'd0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_conflict_cnt  = perf_conflict_q;
  assign perf_cpu_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RD_LAT=1 instance with a memory model and
// an RD_LAT=3 instance whose mem_rdata is driven cycle by cycle.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [31:0] cpu_wdata = 32'h0;
  logic [3:0]  cpu_wstrb = 4'h0;
  logic        cpu_ready, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0]  dbg_addr = 8'h00;
  logic [31:0] dbg_wdata = 32'h0;
  logic [3:0]  dbg_wstrb = 4'h0;
  logic        dbg_ready;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem [256];

  logic        c3_req = 1'b0;
  logic [7:0]  c3_addr = 8'h00;
  logic        c3_ready, c3_stall, d3_ready, m3_en, m3_we;
  logic [31:0] c3_rdata, d3_rdata, m3_wdata;
  logic [31:0] m3_rdata = 32'h0;
  logic [7:0]  m3_addr;
  logic [3:0]  m3_wstrb;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_stall, p3_conflict, p3_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wstrb(dbg_wstrb), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict), .perf_cpu_stall_cnt(perf_stall)
`endif
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(32'h0),
    .cpu_wstrb(4'h0), .cpu_ready(c3_ready), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(8'h00), .dbg_wdata(32'h0),
    .dbg_wstrb(4'h0), .dbg_ready(d3_ready), .dbg_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_wstrb(m3_wstrb), .mem_rdata(m3_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_conflict_cnt(p3_conflict), .perf_cpu_stall_cnt(p3_stall)
`endif
  );

  // Single-port memory model, one cycle read latency, byte strobes on writes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic test_reset;
    reset = 1'b1; mem_init = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
    n_checks++; if (dbg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_ready: got %b want 0", dbg_ready); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
    n_checks++; if (mem_addr !== 8'h00 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_mem_addr_strb: got %h/%h want 00/0", mem_addr, mem_wstrb); end
    n_checks++; if (mem_wdata !== 32'h0 || m3_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h/%h want 0", mem_wdata, m3_wdata); end
    n_checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", cpu_rdata, dbg_rdata); end
    n_checks++; if (u_dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", u_dut.state_q); end
    reset = 1'b0; mem_init = 1'b0;
  endtask

  task automatic test_cpu_write_read;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF; end
      #1;
      n_checks++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL wr_mem_en c%0d: got %b", c, mem_en); end
      n_checks++; if (cpu_ready !== (c == 2)) begin n_fail++; $display("FAIL wr_cpu_ready c%0d: got %b", c, cpu_ready); end
      n_checks++; if (cpu_stall !== (c < 2)) begin n_fail++; $display("FAIL wr_cpu_stall c%0d: got %b", c, cpu_stall); end
      if (c == 1) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF) begin
          n_fail++; $display("FAIL wr_mem_cmd: got we=%b a=%h d=%h s=%h want 1/10/DEADBEEF/F", mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
      end
      if (c == 2) cpu_req = 1'b0;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; end
      #1;
      n_checks++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL rd_mem_en c%0d: got %b", c, mem_en); end
      n_checks++; if (cpu_ready !== (c == 3)) begin n_fail++; $display("FAIL rd_cpu_ready c%0d: got %b", c, cpu_ready); end
      n_checks++; if (cpu_stall !== (c < 3)) begin n_fail++; $display("FAIL rd_cpu_stall c%0d: got %b", c, cpu_stall); end
      if (c == 1) begin
        n_checks++; if (mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rd_mem_we_strb: got %b/%h want 0/0", mem_we, mem_wstrb); end
      end
      if (c == 3) begin
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_cpu_rdata: got %h want DEADBEEF", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention;
    logic [7:0] exp_addr [6];
    int grants = 0;
    int dbg_pulses = 0;
    exp_addr = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h21, 8'h20};
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'h1; cpu_wstrb = 4'hF;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h21; dbg_wdata = 32'h2; dbg_wstrb = 4'hF;
      end
      #1;
      if (mem_en === 1'b1) begin
        if (grants < 6) begin
          n_checks++; if (mem_addr !== exp_addr[grants]) begin n_fail++; $display("FAIL contention_grant%0d: got addr %h want %h", grants, mem_addr, exp_addr[grants]); end
        end
        grants++;
      end
      if (dbg_ready === 1'b1) dbg_pulses++;
      n_checks++; if (cpu_ready === 1'b1 && dbg_ready === 1'b1) begin n_fail++; $display("FAIL contention_both_ready c%0d: got 11 want not both", c); end
      if (c == 17) begin cpu_req = 1'b0; dbg_req = 1'b0; end
    end
    n_checks++; if (grants !== 6) begin n_fail++; $display("FAIL contention_grants: got %0d want 6", grants); end
    n_checks++; if (dbg_pulses !== 1) begin n_fail++; $display("FAIL contention_dbg_ready: got %0d want 1", dbg_pulses); end
  endtask

  task automatic test_byte_strobe;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h03; dbg_wdata = 32'h000000AA; dbg_wstrb = 4'b0001; end
      #1;
      n_checks++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL strb_mem_en c%0d: got %b", c, mem_en); end
      n_checks++; if (dbg_ready !== (c == 2) || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL strb_ready c%0d: got dbg=%b cpu=%b", c, dbg_ready, cpu_ready); end
      if (c == 1) begin
        n_checks++; if (mem_wstrb !== 4'b0001 || mem_we !== 1'b1 || mem_wdata !== 32'hAA) begin n_fail++; $display("FAIL strb_cmd: got s=%b we=%b d=%h want 0001/1/AA", mem_wstrb, mem_we, mem_wdata); end
      end
      if (c == 2) dbg_req = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h03; dbg_wstrb = 4'hF; end
      #1;
      if (c == 1) begin
        n_checks++; if (mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL strb_read_strb: got %b/%b want 0000/0", mem_wstrb, mem_we); end
      end
      n_checks++; if (dbg_ready !== (c == 3)) begin n_fail++; $display("FAIL strb_read_ready c%0d: got %b", c, dbg_ready); end
      if (c == 3) begin
        n_checks++; if (dbg_rdata !== 32'h000000AA) begin n_fail++; $display("FAIL strb_read_rdata: got %h want 000000AA", dbg_rdata); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL strb_cpu_rdata_hold: got %h want DEADBEEF", cpu_rdata); end
        dbg_req = 1'b0;
      end
    end
  endtask

  task automatic test_rd_lat3;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin c3_req = 1'b1; c3_addr = 8'h05; end
      m3_rdata = (c == 4) ? 32'hCAFE0004 : (32'h11110000 + 32'(c));
      #1;
      n_checks++; if (m3_en !== (c == 1)) begin n_fail++; $display("FAIL lat3_mem_en c%0d: got %b", c, m3_en); end
      n_checks++; if (c3_ready !== (c == 5)) begin n_fail++; $display("FAIL lat3_ready c%0d: got %b", c, c3_ready); end
      n_checks++; if (c3_stall !== (c < 5 && c3_req)) begin n_fail++; $display("FAIL lat3_stall c%0d: got %b", c, c3_stall); end
      if (c == 1) begin
        n_checks++; if (m3_addr !== 8'h05 || m3_we !== 1'b0 || m3_wstrb !== 4'h0) begin n_fail++; $display("FAIL lat3_cmd: got a=%h we=%b s=%h want 05/0/0", m3_addr, m3_we, m3_wstrb); end
      end
      if (c == 5) begin
        n_checks++; if (c3_rdata !== 32'hCAFE0004) begin n_fail++; $display("FAIL lat3_rdata: got %h want CAFE0004", c3_rdata); end
        n_checks++; if (d3_ready !== 1'b0 || d3_rdata !== 32'h0) begin n_fail++; $display("FAIL lat3_dbg_idle: got %b/%h want 0/0", d3_ready, d3_rdata); end
        c3_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_read;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; end
      if (c == 2) reset = 1'b1;
      if (c == 3) reset = 1'b0;
      #1;
      if (c == 2) begin
        n_checks++; if (u_dut.state_q !== WAIT) begin n_fail++; $display("FAIL midrst_in_wait: got %0d want 2", u_dut.state_q); end
      end
      if (c == 3) begin
        n_checks++; if (u_dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", u_dut.state_q); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", cpu_rdata); end
      end
      if (c >= 2) begin
        n_checks++; if (mem_en !== (c == 4)) begin n_fail++; $display("FAIL midrst_mem_en c%0d: got %b", c, mem_en); end
      end
      n_checks++; if (cpu_ready !== (c == 6)) begin n_fail++; $display("FAIL midrst_ready c%0d: got %b", c, cpu_ready); end
      if (c == 6) begin
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midrst_reissue_rdata: got %h want DEADBEEF", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (perf_conflict !== 32'd0 || perf_stall !== 32'd0) begin n_fail++; $display("FAIL perf_reset0: got %0d/%0d want 0/0", perf_conflict, perf_stall); end
    reset = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'h5; cpu_wstrb = 4'hF;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 32'h6; dbg_wstrb = 4'hF;
      end
      #1;
      if (c == 16) begin
        n_checks++; if (perf_conflict !== 32'd6) begin n_fail++; $display("FAIL perf_conflict: got %0d want 6", perf_conflict); end
        n_checks++; if (perf_stall !== 32'd12) begin n_fail++; $display("FAIL perf_stall: got %0d want 12", perf_stall); end
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (perf_conflict !== 32'd0 || perf_stall !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_conflict, perf_stall); end
    n_checks++; if (p3_conflict !== 32'd0 || p3_stall !== 32'd0) begin n_fail++; $display("FAIL perf3_reset: got %0d/%0d want 0/0", p3_conflict, p3_stall); end
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_byte_strobe();
    test_rd_lat3();
    test_reset_mid_read();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
